// File: rtl/prim_util_pkg_u.sv
// Shared width helpers for the prim FIFO family.
package prim_util_pkg_u;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/prim_fifo_wm_cnt.sv
// Pointer/occupancy bookkeeping for prim_fifo_sync_wm: wrapping pointers,
// stored depth, full/empty flags and a sticky pointer/depth consistency check.
module prim_fifo_wm_cnt
    import prim_util_pkg_u::*;
#(
    parameter int unsigned Depth  = 8,
    parameter int unsigned DepthW = vbits(Depth + 1),
    parameter int unsigned PtrW   = vbits(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              incr_wptr_i,
    input  logic              incr_rptr_i,
    output logic [PtrW-1:0]   wptr_o,
    output logic [PtrW-1:0]   rptr_o,
    output logic [DepthW-1:0] depth_o,
    output logic [DepthW-1:0] depth_next_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam logic [PtrW-1:0]   PtrMax   = PtrW'(Depth - 1);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(Depth);

    logic [PtrW-1:0]   r_wptr, r_rptr, w_wptr_next, w_rptr_next;
    logic [DepthW-1:0] r_depth, w_depth_next;
    logic [DepthW-1:0] w_wext, w_rext, w_ptr_diff;
    logic              r_err, w_err;

    always_comb begin
        w_wptr_next  = r_wptr;
        w_rptr_next  = r_rptr;
        w_depth_next = r_depth;
        if (clr_i) begin
            w_wptr_next  = '0;
            w_rptr_next  = '0;
            w_depth_next = '0;
        end else begin
            if (incr_wptr_i) w_wptr_next = (r_wptr == PtrMax) ? '0 : r_wptr + 1'b1;
            if (incr_rptr_i) w_rptr_next = (r_rptr == PtrMax) ? '0 : r_rptr + 1'b1;
            if (incr_wptr_i && !incr_rptr_i)      w_depth_next = r_depth + 1'b1;
            else if (!incr_wptr_i && incr_rptr_i) w_depth_next = r_depth - 1'b1;
        end
    end

    // Equal pointers mean empty or full; the stored depth disambiguates.
    assign w_wext     = DepthW'(r_wptr);
    assign w_rext     = DepthW'(r_rptr);
    assign w_ptr_diff = (w_wext >= w_rext) ? (w_wext - w_rext) : (w_wext + DepthMax - w_rext);
    assign w_err      = (r_depth > DepthMax) ||
                        ((r_depth == DepthMax) ? (w_ptr_diff != '0) : (r_depth != w_ptr_diff));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_next;
            r_rptr  <= w_rptr_next;
            r_depth <= w_depth_next;
            if (w_err) r_err <= 1'b1;
        end
    end

    assign wptr_o       = r_wptr;
    assign rptr_o       = r_rptr;
    assign depth_o      = r_depth;
    assign depth_next_o = w_depth_next;
    assign full_o       = (r_depth == DepthMax);
    assign empty_o      = (r_depth == '0);
    assign err_o        = r_err;

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Synchronous FIFO with optional pass-through, programmable low/high
// watermarks with rising-edge events, and a peak-occupancy tracker.
module prim_fifo_sync_wm
    import prim_util_pkg_u::*;
#(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 8,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    localparam int unsigned DepthW           = vbits(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] thr_lo_i,
    input  logic [DepthW-1:0] thr_hi_i,
    output logic              wm_lo_o,
    output logic              wm_hi_o,
    output logic              wm_lo_evt_o,
    output logic              wm_hi_evt_o,
    output logic [DepthW-1:0] peak_o,
    input  logic              peak_clr_i,
    output logic              err_o
);

    localparam int unsigned PtrW = vbits(Depth);

    if (Depth < 2 || Depth > 256) begin : g_depth_check
        $error("prim_fifo_sync_wm: Depth must be within 2..256");
    end

    logic [PtrW-1:0]   w_wptr, w_rptr;
    logic [DepthW-1:0] w_depth, w_depth_next;
    logic              w_full, w_empty, w_err;
    logic              w_wready, w_rvalid, w_push, w_pop, w_bypass;
    logic              w_incr_wptr, w_incr_rptr;
    logic [Width-1:0]  w_rdata_raw;
    logic              w_wm_lo, w_wm_hi;
    logic              r_wm_lo_q, r_wm_hi_q;
    logic [DepthW-1:0] r_peak;
    logic [Width-1:0]  r_mem [Depth];

    assign w_wready = ~w_full & ~rst_i;
    assign w_rvalid = ~rst_i & (~w_empty | (Pass & wvalid_i));
    assign w_push   = wvalid_i & w_wready;
    assign w_pop    = w_rvalid & rready_i;

    // A same-cycle write and read on an empty FIFO never touches storage.
    assign w_bypass    = Pass & w_empty & w_push & w_pop;
    assign w_incr_wptr = w_push & ~w_bypass;
    assign w_incr_rptr = w_pop & ~w_bypass;

    prim_fifo_wm_cnt #(
        .Depth  (Depth),
        .DepthW (DepthW),
        .PtrW   (PtrW)
    ) u_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr_i),
        .incr_wptr_i  (w_incr_wptr),
        .incr_rptr_i  (w_incr_rptr),
        .wptr_o       (w_wptr),
        .rptr_o       (w_rptr),
        .depth_o      (w_depth),
        .depth_next_o (w_depth_next),
        .full_o       (w_full),
        .empty_o      (w_empty),
        .err_o        (w_err)
    );

    always_ff @(posedge clk_i) begin
        if (w_incr_wptr) r_mem[w_wptr] <= wdata_i;
    end

    assign w_rdata_raw = (Pass && w_empty) ? wdata_i : r_mem[w_rptr];

    always_comb begin
        rdata_o = w_rdata_raw;
        if (rst_i || (OutputZeroIfEmpty && !w_rvalid)) rdata_o = '0;
    end

    assign w_wm_lo = (w_depth <= thr_lo_i);
    assign w_wm_hi = (w_depth >= thr_hi_i);

    // Low-watermark history resets high so leaving reset at depth 0 is silent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wm_lo_q <= 1'b1;
            r_wm_hi_q <= 1'b0;
        end else begin
            r_wm_lo_q <= w_wm_lo;
            r_wm_hi_q <= w_wm_hi;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_peak <= '0;
        end else if (peak_clr_i) begin
            r_peak <= w_depth_next;
        end else if (w_depth_next > r_peak) begin
            r_peak <= w_depth_next;
        end
    end

    assign wready_o    = w_wready;
    assign rvalid_o    = w_rvalid;
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign depth_o     = w_depth;
    assign wm_lo_o     = w_wm_lo;
    assign wm_hi_o     = w_wm_hi;
    assign wm_lo_evt_o = ~rst_i & w_wm_lo & ~r_wm_lo_q;
    assign wm_hi_evt_o = ~rst_i & w_wm_hi & ~r_wm_hi_q;
    assign peak_o      = r_peak;
    assign err_o       = w_err;

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Scoreboard bench for prim_fifo_sync_wm: a Depth=5 pass-through instance
// driven cycle by cycle against a queue model, plus a Depth=4 registered one.
module tb_prim_fifo_sync_wm;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 5;
    localparam int unsigned DW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, wvalid, rready, peak_clr;
    logic [W-1:0]  wdata, rdata;
    logic [DW-1:0] thr_lo, thr_hi, depth, peak;
    logic          wready, rvalid, full, empty, wm_lo, wm_hi, lo_evt, hi_evt, err;

    logic          n_wvalid, n_rready, n_wready, n_rvalid, n_full, n_empty;
    logic [W-1:0]  n_wdata, n_rdata;
    logic [DW-1:0] n_depth, n_peak;
    logic          n_wm_lo, n_wm_hi, n_lo_evt, n_hi_evt, n_err;
    logic          n_clr = 1'b0, n_peak_clr = 1'b0;
    logic [DW-1:0] n_thr_lo = '0, n_thr_hi = '0;

    prim_fifo_sync_wm #(.Width(W), .Depth(D), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .full_o(full), .empty_o(empty), .depth_o(depth),
        .thr_lo_i(thr_lo), .thr_hi_i(thr_hi),
        .wm_lo_o(wm_lo), .wm_hi_o(wm_hi), .wm_lo_evt_o(lo_evt), .wm_hi_evt_o(hi_evt),
        .peak_o(peak), .peak_clr_i(peak_clr), .err_o(err)
    );

    prim_fifo_sync_wm #(.Width(W), .Depth(4), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) dut_np (
        .clk_i(clk), .rst_i(rst), .clr_i(n_clr),
        .wvalid_i(n_wvalid), .wready_o(n_wready), .wdata_i(n_wdata),
        .rvalid_o(n_rvalid), .rready_i(n_rready), .rdata_o(n_rdata),
        .full_o(n_full), .empty_o(n_empty), .depth_o(n_depth),
        .thr_lo_i(n_thr_lo), .thr_hi_i(n_thr_hi),
        .wm_lo_o(n_wm_lo), .wm_hi_o(n_wm_hi), .wm_lo_evt_o(n_lo_evt), .wm_hi_evt_o(n_hi_evt),
        .peak_o(n_peak), .peak_clr_i(n_peak_clr), .err_o(n_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    logic [W-1:0] sb[$];
    logic [W-1:0] nq[$];
    int unsigned  m_depth = 0;
    int unsigned  m_peak  = 0;
    logic         m_lo_q  = 1'b1;
    logic         m_hi_q  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of the main DUT: drive, check comb outputs at negedge, then registered ones.
    task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr);
        logic exp_wready, exp_rvalid, lvl_lo, lvl_hi;
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        @(negedge clk);
        exp_wready = !rst && (m_depth != D);
        exp_rvalid = !rst && (m_depth != 0 || wv);
        lvl_lo     = (m_depth <= 32'(thr_lo));
        lvl_hi     = (m_depth >= 32'(thr_hi));
        chk("wready", 32'(wready), 32'(exp_wready));
        chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
        chk("lo_evt_pre", 32'(lo_evt), 32'(!rst && lvl_lo && !m_lo_q));
        chk("hi_evt_pre", 32'(hi_evt), 32'(!rst && lvl_hi && !m_hi_q));
        if (!exp_rvalid) chk("rdata_zero", 32'(rdata), 32'd0);
        if (rst || clr) begin
            sb.delete();
        end else begin
            if (wv && exp_wready) sb.push_back(wd);
            if (exp_rvalid && rr) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else chk("rdata", 32'(rdata), 32'(sb.pop_front()));
            end
        end
        m_lo_q = rst ? 1'b1 : lvl_lo;
        m_hi_q = rst ? 1'b0 : lvl_hi;
        @(posedge clk);
        #1;
        m_depth = sb.size();
        if (rst || clr)          m_peak = 0;
        else if (peak_clr)       m_peak = m_depth;
        else if (m_depth > m_peak) m_peak = m_depth;
        lvl_lo = (m_depth <= 32'(thr_lo));
        lvl_hi = (m_depth >= 32'(thr_hi));
        chk("depth", 32'(depth), m_depth);
        chk("full", 32'(full), 32'(m_depth == D));
        chk("empty", 32'(empty), 32'(m_depth == 0));
        chk("wm_lo", 32'(wm_lo), 32'(lvl_lo));
        chk("wm_hi", 32'(wm_hi), 32'(lvl_hi));
        chk("lo_evt", 32'(lo_evt), 32'(!rst && lvl_lo && !m_lo_q));
        chk("hi_evt", 32'(hi_evt), 32'(!rst && lvl_hi && !m_hi_q));
        chk("peak", 32'(peak), m_peak);
        chk("err", 32'(err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; peak_clr = 1'b0;
        wvalid = 1'b0; rready = 1'b0; wdata = '0;
        thr_lo = DW'(1); thr_hi = DW'(4);
        n_wvalid = 1'b0; n_rready = 1'b0; n_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held with a write request: outputs must stay quiet.
        step(1'b1, 16'h1111, 1'b1);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);

        // Registered (Pass=0) instance: fill, overflow attempt, drain in order.
        for (int i = 0; i < 4; i++) begin
            n_wvalid = 1'b1;
            n_wdata  = 16'hA1 + 16'(i);
            @(negedge clk);
            if (i == 0) chk("np_no_bypass", 32'(n_rvalid), 32'd0);
            chk("np_wready", 32'(n_wready), 32'd1);
            nq.push_back(n_wdata);
            @(posedge clk);
            #1;
        end
        chk("np_full", 32'(n_full), 32'd1);
        chk("np_wready_full", 32'(n_wready), 32'd0);
        chk("np_depth4", 32'(n_depth), 32'd4);
        n_wvalid = 1'b0;
        n_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("np_rvalid", 32'(n_rvalid), 32'd1);
            chk("np_rdata", 32'(n_rdata), 32'(nq.pop_front()));
            @(posedge clk);
            #1;
        end
        n_rready = 1'b0;
        chk("np_empty", 32'(n_empty), 32'd1);
        chk("np_depth0", 32'(n_depth), 32'd0);

        // Pass-through on empty.
        step(1'b1, 16'h0055, 1'b1);

        // Fill past full, pop while full with a write pending, drain towards low mark.
        for (int i = 0; i < 6; i++) step(1'b1, 16'hB0 + 16'(i), 1'b0);
        step(1'b1, 16'hBF, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Threshold edges: hi=0 always asserted, lo>=Depth always asserted.
        thr_hi = DW'(0);
        step(1'b0, '0, 1'b0);
        thr_lo = DW'(5);
        thr_hi = DW'(4);
        step(1'b0, '0, 1'b0);
        thr_lo = DW'(1);
        step(1'b0, '0, 1'b0);

        // Peak clear with three entries stored.
        step(1'b1, 16'hC1, 1'b0);
        step(1'b1, 16'hC2, 1'b0);
        peak_clr = 1'b1;
        step(1'b0, '0, 1'b0);
        peak_clr = 1'b0;

        // Random interleaving across pointer wrap.
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));

        // Flush a full FIFO while writing and reading.
        for (int i = 0; i < 6; i++) step(1'b1, 16'hD0 + 16'(i), 1'b0);
        clr = 1'b1;
        step(1'b1, 16'hDD, 1'b1);
        clr = 1'b0;
        step(1'b0, '0, 1'b1);

        // Reset in the middle of a burst, then resume.
        for (int i = 0; i < 3; i++) step(1'b1, 16'hE0 + 16'(i), 1'b0);
        rst = 1'b1;
        step(1'b1, 16'hEE, 1'b0);
        step(1'b1, 16'hEF, 1'b1);
        rst = 1'b0;
        step(1'b1, 16'hF1, 1'b0);
        step(1'b1, 16'hF2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
